viterbi_frame_ctrl: RTL and testbench

Frame sequencer in front of `viterbi_decoder_top`. It accepts hard-decision symbol pairs over a valid/ready stream and buffers one frame. It then drives the decoder's `en`/`d_in` feed sequence, including the tail symbol. Finally it collects the traceback bits qualified by `d_valid` and presents the decoded frame on a valid/ready output with a completion counter and a timeout error flag.

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/viterbi_sym_buf.sv | 37 +++
 rtl/viterbi_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and default sizing for the Viterbi frame controller and decoder top.
package viterbi_pkg;

    localparam int unsigned SYM_W = 2;
    localparam logic [SYM_W-1:0] SYM_ZERO = 2'b00;

    localparam int unsigned DEF_FRAME_SYMS = 8;
    localparam int unsigned DEF_TAIL_SYMS  = 1;
    localparam int unsigned DEF_TIMEOUT    = 32;

    typedef enum logic [1:0] {
        StCollect,
        StFeed,
        StDrain,
        StOut
    } ctrl_state_t;

endpackage

// File: rtl/viterbi_sym_buf.sv
// One-frame symbol store: synchronous write port, combinational indexed read, cleared on reset.
module viterbi_sym_buf
    import viterbi_pkg::*;
#(
    parameter int unsigned Depth = DEF_FRAME_SYMS,
    parameter int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [IdxW-1:0]  wr_idx_i,
    input  logic [SYM_W-1:0] wr_data_i,
    input  logic [IdxW-1:0]  rd_idx_i,
    output logic [SYM_W-1:0] rd_data_o
);

    logic [SYM_W-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= SYM_ZERO;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Indices past the frame read as the zero symbol so tail reads need no special casing.
    always_comb begin
        rd_data_o = SYM_ZERO;
        if (32'(rd_idx_i) < Depth) begin
            rd_data_o = mem_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: buffers one frame of symbol pairs, feeds the decoder, collects
// the traceback bits and hands the decoded frame off over valid/ready.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_SYMS = DEF_FRAME_SYMS,
    parameter int unsigned TAIL_SYMS  = DEF_TAIL_SYMS,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic [SYM_W-1:0]      sym_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FRAME_SYMS-1:0] out_data,
    output logic                  out_err,
    output logic [15:0]           frame_cnt,
    output logic                  busy,
    output logic                  dec_en,
    output logic [SYM_W-1:0]      dec_din,
    input  logic                  dec_dout,
    input  logic                  dec_dvalid
);

    localparam int unsigned FeedLen = FRAME_SYMS + TAIL_SYMS;
    localparam int unsigned IdxW    = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
    localparam int unsigned KW      = $clog2(FeedLen + 1);
    localparam int unsigned BitW    = $clog2(FRAME_SYMS + 1);
    localparam int unsigned TmrW    = $clog2(TIMEOUT + 1);

    localparam logic [IdxW-1:0] IdxLast  = IdxW'(FRAME_SYMS - 1);
    localparam logic [KW-1:0]   KLast    = KW'(FeedLen - 1);
    localparam logic [BitW-1:0] BitsLast = BitW'(FRAME_SYMS - 1);
    localparam logic [TmrW-1:0] TmrLimit = TmrW'(TIMEOUT);

    ctrl_state_t           state_q, state_d;
    logic [IdxW-1:0]       wr_idx_q, wr_idx_d;
    logic [KW-1:0]         k_q, k_d, k_nxt;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TmrW-1:0]       tmr_q, tmr_d;
    logic [FRAME_SYMS-1:0] sr_q, sr_d, sr_shift;
    logic                  out_valid_q, out_valid_d;
    logic [FRAME_SYMS-1:0] out_data_q, out_data_d;
    logic                  out_err_q, out_err_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  dec_en_q, dec_en_d;
    logic [SYM_W-1:0]      dec_din_q, dec_din_d;

    logic                  buf_we;
    logic [IdxW-1:0]       buf_rd_idx;
    logic [SYM_W-1:0]      buf_rd_data;

    viterbi_sym_buf #(
        .Depth (FRAME_SYMS),
        .IdxW  (IdxW)
    ) u_sym_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (buf_we),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (sym_data),
        .rd_idx_i  (buf_rd_idx),
        .rd_data_o (buf_rd_data)
    );

    // Decoder feed outputs are registered, so they are computed one cycle ahead from k+1.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        k_d         = k_q;
        bit_cnt_d   = bit_cnt_q;
        tmr_d       = tmr_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        frame_cnt_d = frame_cnt_q;
        dec_en_d    = 1'b0;
        dec_din_d   = SYM_ZERO;
        buf_we      = 1'b0;
        buf_rd_idx  = '0;
        k_nxt       = k_q + 1'b1;
        sr_shift    = {sr_q[FRAME_SYMS-2:0], dec_dout};

        unique case (state_q)
            StCollect: begin
                if (sym_valid) begin
                    buf_we = 1'b1;
                    if (wr_idx_q == IdxLast) begin
                        wr_idx_d  = '0;
                        k_d       = '0;
                        state_d   = StFeed;
                        dec_en_d  = 1'b1;
                        // Single-symbol frames write buf[0] on this very edge.
                        dec_din_d = (wr_idx_q == '0) ? sym_data : buf_rd_data;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            StFeed: begin
                buf_rd_idx = IdxW'(k_nxt);
                if (k_q == KLast) begin
                    state_d   = StDrain;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                    tmr_d     = '0;
                end else begin
                    k_d = k_nxt;
                    if (32'(k_nxt) < FRAME_SYMS) begin
                        dec_din_d = buf_rd_data;
                    end
                end
            end
            StDrain: begin
                tmr_d = tmr_q + 1'b1;
                if (dec_dvalid) begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // A bit landing in the timeout cycle still counts and wins if it completes.
                if (dec_dvalid && (bit_cnt_q == BitsLast)) begin
                    state_d     = StOut;
                    out_valid_d = 1'b1;
                    out_data_d  = sr_shift;
                    out_err_d   = 1'b0;
                end else if (tmr_d == TmrLimit) begin
                    state_d     = StOut;
                    out_valid_d = 1'b1;
                    out_data_d  = sr_d;
                    out_err_d   = 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StCollect;
            wr_idx_q    <= '0;
            k_q         <= '0;
            bit_cnt_q   <= '0;
            tmr_q       <= '0;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            dec_en_q    <= 1'b0;
            dec_din_q   <= SYM_ZERO;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            k_q         <= k_d;
            bit_cnt_q   <= bit_cnt_d;
            tmr_q       <= tmr_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            frame_cnt_q <= frame_cnt_d;
            dec_en_q    <= dec_en_d;
            dec_din_q   <= dec_din_d;
        end
    end

    // Held low during reset so no symbol appears accepted while the frame is being discarded.
    assign sym_ready = (state_q == StCollect) && !rst;
    assign busy      = (state_q != StCollect);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign frame_cnt = frame_cnt_q;
    assign dec_en    = dec_en_q;
    assign dec_din   = dec_din_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl with a timing-accurate decoder stub.
module tb_viterbi_frame_ctrl;
    import viterbi_pkg::*;

    localparam int unsigned FS   = DEF_FRAME_SYMS;
    localparam int unsigned TS   = DEF_TAIL_SYMS;
    localparam int          IDLE = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [1:0] sym_data = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_err;
    logic [15:0] frame_cnt;
    logic       busy;
    logic       dec_en;
    logic [1:0] dec_din;
    logic       dec_dout = 1'b0;
    logic       dec_dvalid = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_frame_t;

    exp_frame_t sb_q[$];
    logic [1:0] acc_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] stub_pat = 8'h00;
    int         stub_n = 0;
    int         stub_cnt = IDLE;
    logic [4:0] tog_pat = 5'b10110;

    int         feed_k = -1;
    logic [1:0] feed_exp [FS];
    int         last_acc_cur = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_err = 1'b0;
    logic       cnt_pending = 1'b0;
    int         exp_cnt = 0;
    exp_frame_t mon_e;

    viterbi_frame_ctrl #(
        .FRAME_SYMS (FS),
        .TAIL_SYMS  (TS),
        .TIMEOUT    (DEF_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_data   (sym_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .dec_en     (dec_en),
        .dec_din    (dec_din),
        .dec_dout   (dec_dout),
        .dec_dvalid (dec_dvalid)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] data, input logic err, input int lat);
        exp_frame_t e;
        e.data = data;
        e.err  = err;
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    // Decoder stub: MIN cycle 9 cycles after en, then stub_n bits of stub_pat, MSB first.
    initial forever begin
        @(posedge clk);
        #2;
        if (rst) stub_cnt = IDLE;
        else if (dec_en) stub_cnt = 0;
        if (stub_cnt >= 10 && stub_cnt < 10 + stub_n) begin
            dec_dvalid = 1'b1;
            dec_dout   = stub_pat[7 - (stub_cnt - 10)];
        end else begin
            dec_dvalid = 1'b0;
            dec_dout   = 1'($urandom_range(0, 1));
        end
        if (stub_cnt < IDLE) stub_cnt++;
    end

    // Monitor: accept tracking, feed order, output hold/handshake and frame counter.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            feed_k      = -1;
            acc_q.delete();
            sb_q.delete();
            exp_cnt     = 0;
            prev_valid  = 1'b0;
            cnt_pending = 1'b0;
        end else begin
            if (cnt_pending) begin
                check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
                cnt_pending = 1'b0;
            end
            if (sym_valid && sym_ready) begin
                acc_q.push_back(sym_data);
                last_acc_cur = cyc;
            end
            if (feed_k < 0 && dec_en) begin
                for (int i = 0; i < int'(FS); i++) begin
                    feed_exp[i] = (acc_q.size() > 0) ? acc_q.pop_front() : 2'bxx;
                end
                feed_k = 0;
            end
            if (feed_k >= 0) begin
                if (feed_k < int'(FS + TS)) begin
                    check_eq("feed_en", 32'(dec_en), 32'(feed_k == 0));
                    check_eq("feed_din", 32'(dec_din),
                             32'((feed_k < int'(FS)) ? feed_exp[feed_k] : 2'b00));
                    feed_k++;
                end else begin
                    check_eq("feed_end_en", 32'(dec_en), 32'd0);
                    check_eq("feed_end_din", 32'(dec_din), 32'd0);
                    feed_k = -1;
                end
            end else begin
                check_eq("idle_din", 32'(dec_din), 32'd0);
            end
            if (out_valid) begin
                check_eq("out_state", 32'({sym_ready, busy, dec_en}), 32'b010);
                if (prev_valid) begin
                    check_eq("hold_data", 32'(out_data), 32'(prev_data));
                    check_eq("hold_err", 32'(out_err), 32'(prev_err));
                end else begin
                    check_eq("out_expected", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) check_eq("latency", 32'(cyc - last_acc_cur), 32'(sb_q[0].lat));
                end
                if (out_ready) begin
                    if (sb_q.size() > 0) begin
                        mon_e = sb_q.pop_front();
                        check_eq("out_data", 32'(out_data), 32'(mon_e.data));
                        check_eq("out_err", 32'(out_err), 32'(mon_e.err));
                    end
                    exp_cnt++;
                    cnt_pending = 1'b1;
                end
            end
            prev_valid = out_valid && !out_ready;
            prev_data  = out_data;
            prev_err   = out_err;
        end
    end

    task automatic send_frame(input logic [15:0] syms, input bit toggle);
        int i = 0;
        int t = 0;
        int guard = 0;
        bit hs;
        while (i < int'(FS) && guard < 200) begin
            sym_valid = toggle ? tog_pat[4 - (t % 5)] : 1'b1;
            t++;
            sym_data = sym_valid ? syms[15 - 2 * i -: 2] : 2'($urandom);
            @(negedge clk);
            hs = sym_valid && sym_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
        end
        sym_valid = 1'b0;
        if (guard >= 200) check_eq("send_done", 32'(i), 32'(FS));
    endtask

    task automatic recv_frame(input int hold, input bit early);
        int w = 0;
        out_ready = early;
        while (!out_valid && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!out_valid) begin
            check_eq("out_wait", 32'(out_valid), 32'd1);
            out_ready = 1'b0;
            return;
        end
        if (!early) begin
            sym_valid = (hold > 0);
            for (int h = 0; h < hold; h++) begin
                sym_data = 2'($urandom);
                @(posedge clk);
                #1;
            end
            sym_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] syms;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_sym_ready", 32'(sym_ready), 32'd0);
        check_eq("rst_outs", 32'({out_valid, out_err, busy, dec_en, dec_din}), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(sym_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reference frame, output accepted in the same cycle it appears.
        stub_pat = 8'b00100110;
        stub_n   = 8;
        push_exp(8'b00100110, 1'b0, 19);
        send_frame(16'b0000_0101_1111_1011, 1'b0);
        recv_frame(0, 1'b1);

        // Backpressure: five cycles held in OUT with symbols offered.
        stub_pat = 8'($urandom);
        push_exp(stub_pat, 1'b0, 19);
        send_frame(16'($urandom), 1'b0);
        recv_frame(5, 1'b0);

        // Decoder goes silent after five bits.
        stub_pat = 8'b10110_000;
        stub_n   = 5;
        push_exp(8'b00010110, 1'b1, 42);
        send_frame(16'($urandom), 1'b0);
        recv_frame(2, 1'b0);

        // Gapped input stream.
        stub_pat = 8'($urandom);
        stub_n   = 8;
        push_exp(stub_pat, 1'b0, 19);
        send_frame(16'($urandom), 1'b1);
        recv_frame(0, 1'b0);

        // Reset in the middle of the feed (k=4) discards the frame.
        send_frame(16'($urandom), 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready_low", 32'({sym_ready, busy}), 32'b01);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_dec", 32'({dec_en, dec_din}), 32'd0);
        check_eq("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("midrst_ready", 32'({sym_ready, busy, out_valid}), 32'b100);
        @(posedge clk);
        #1;

        syms     = 16'($urandom);
        stub_pat = 8'($urandom);
        push_exp(stub_pat, 1'b0, 19);
        send_frame(syms, 1'b0);
        recv_frame(1, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
